rvfi_commit_serializer: RTL and testbench

Sits between the core's multi-port RVFI commit interface and single-record trace consumers (the RVFI tracer instantiated with NR_COMMIT_PORTS=1, or a lock-step checker). Captures up to NR_COMMIT_PORTS retired or trapped records per cycle and queues them in program order. It emits them one per cycle over a valid/ready handshake, tagging each record with a monotonically increasing order number. Overflow is never silent: dropped records are counted and flagged.

---
 rtl/rvfi_pkg.sv | 42 ++++
 rtl/rvfi_commit_serializer_if.sv | 14 +
 rtl/rvfi_mpush_fifo.sv | 62 ++++++
 rtl/rvfi_commit_serializer.sv | 94 +++++++++
 tb/tb_rvfi_commit_serializer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_pkg.sv
// RVFI commit record, queue entry and candidate helpers shared by the serializer and its FIFO.
// No logic here: types and pure functions only.
package rvfi_pkg;

    localparam int unsigned MAX_COMMIT_PORTS = 8;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
        logic [63:0] pc_rdata;
        logic [63:0] pc_wdata;
    } rvfi_instr_t;

    typedef struct packed {
        rvfi_instr_t rec;
        logic [63:0] order;
    } rvfi_q_entry_t;

    function automatic logic is_candidate(input rvfi_instr_t r);
        return r.valid | r.trap;
    endfunction

    // Population count over the per-port candidate flags, zero-padded to MAX_COMMIT_PORTS.
    function automatic logic [3:0] candidate_count(input logic [MAX_COMMIT_PORTS-1:0] cand_mask);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_COMMIT_PORTS; i++) begin
            cnt = cnt + {3'b000, cand_mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rvfi_commit_serializer_if.sv
// Single-record trace stream: head record, its order tag and a valid/ready handshake.
// The master holds valid independent of ready; the slave accepts the head with ready.
interface rvfi_commit_serializer_if;
    import rvfi_pkg::*;

    rvfi_instr_t rvfi_o;
    logic [63:0] order_o;
    logic        valid_o;
    logic        ready_i;

    modport master (output rvfi_o, order_o, valid_o, input ready_i);
    modport slave  (input rvfi_o, order_o, valid_o, output ready_i);

endinterface

// File: rtl/rvfi_mpush_fifo.sv
// N-write/1-read circular buffer: up to NR entries pushed per cycle, one popped; head readable same cycle.
// Latency 1 cycle push-to-head; caller must never push more than free_o, which already credits this cycle's pop.
module rvfi_mpush_fifo
    import rvfi_pkg::*;
#(
    parameter int unsigned NR    = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  rvfi_q_entry_t     wr_dat_i [NR],
    input  logic [CNT_W-1:0]  wr_num_i,
    output logic [CNT_W-1:0]  free_o,
    output rvfi_q_entry_t     rd_dat_o,
    output logic              rd_vld_o,
    input  logic              rd_rdy_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    rvfi_q_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign rd_vld_o = (count_q != '0);
    assign pop      = rd_vld_o & rd_rdy_i;
    assign free_o   = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_num_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + wr_num_i - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR; i++) begin
            if (CNT_W'(i) < wr_num_i) begin
                mem_q[wr_ptr_q + PTR_W'(i)] <= wr_dat_i[i];
            end
        end
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes up to NR_COMMIT_PORTS RVFI commits per cycle into one order-tagged record per cycle.
// Latency 1 cycle commit-to-head; no backpressure to the core, overflowing candidates are dropped and counted.
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned CNT_W           = $clog2(DEPTH) + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  rvfi_instr_t                      rvfi_i [NR_COMMIT_PORTS],
    rvfi_commit_serializer_if.master         trace_o,
    output logic [CNT_W-1:0]                 count_o,
    output logic                             overflow_o,
    output logic [31:0]                      drop_cnt_o
);

    logic [MAX_COMMIT_PORTS-1:0] cand_mask;
    logic [CNT_W-1:0]            n_cand, n_acc, n_drop, free, rank;
    rvfi_q_entry_t               wr_dat [NR_COMMIT_PORTS];
    rvfi_q_entry_t               rd_dat;
    logic [63:0]                 order_q, order_d;
    logic [31:0]                 drop_q, drop_d;
    logic [32:0]                 drop_sum;
    logic                        ovf_q, ovf_d;

    always_comb begin
        cand_mask = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            cand_mask[k] = is_candidate(rvfi_i[k]);
        end
    end

    assign n_cand = CNT_W'(candidate_count(cand_mask));
    assign n_acc  = (n_cand < free) ? n_cand : free;
    assign n_drop = n_cand - n_acc;

    // Compact candidates into slots by rank; slots at or above n_acc are ignored by the FIFO.
    always_comb begin
        wr_dat = '{default: '0};
        rank   = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
                if (cand_mask[k] && (rank == CNT_W'(j))) begin
                    wr_dat[j] = '{rec: rvfi_i[k], order: order_q + 64'(rank)};
                end
            end
            rank = rank + CNT_W'(cand_mask[k]);
        end
    end

    rvfi_mpush_fifo #(
        .NR    (NR_COMMIT_PORTS),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_dat_i (wr_dat),
        .wr_num_i (n_acc),
        .free_o   (free),
        .rd_dat_o (rd_dat),
        .rd_vld_o (trace_o.valid_o),
        .rd_rdy_i (trace_o.ready_i),
        .count_o  (count_o)
    );

    // Dropped candidates still consume order numbers so gaps stay visible downstream.
    always_comb begin
        order_d  = order_q + 64'(n_cand);
        drop_sum = {1'b0, drop_q} + 33'(n_drop);
        drop_d   = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        ovf_d    = ovf_q | (n_drop != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            order_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            order_q <= order_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign trace_o.rvfi_o  = rd_dat.rec;
    assign trace_o.order_o = rd_dat.order;
    assign overflow_o      = ovf_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: directed table, corner sequences and random traffic against a queue model.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    rvfi_instr_t      rvfi_i [NR];
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
    logic [31:0]      drop_cnt_o;

    rvfi_commit_serializer_if trace_if();

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS (NR),
        .DEPTH           (DEPTH),
        .CNT_W           (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rvfi_i     (rvfi_i),
        .trace_o    (trace_if),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        rvfi_instr_t rec;
        logic [63:0] ord;
    } m_ent_t;

    m_ent_t      mq[$];
    logic [63:0] m_order;
    logic [31:0] m_drop;
    logic        m_ovf;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        rdy;
        logic        v0, t0;
        logic [63:0] pc0;
        logic        v1, t1;
        logic [63:0] pc1;
        logic        e_vld;
        logic [63:0] e_pc;
        logic [63:0] e_ord;
        logic [3:0]  e_cnt;
        logic        e_ovf;
        logic [31:0] e_drop;
    } vec_t;

    vec_t        vecs [14];
    logic [63:0] drain1 [7];
    logic [63:0] drain2 [8];

    function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [63:0] pc);
        rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 64'd4;
        r.insn     = pc[31:0] ^ 32'h0000_0013;
        r.rd_addr  = pc[6:2];
        r.rd_wdata = ~pc;
        r.order    = pc ^ 64'h55;
        r.mode     = 2'b11;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input rvfi_instr_t act, input rvfi_instr_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc 0x%0h insn 0x%0h expected pc 0x%0h insn 0x%0h",
                     name, act.pc_rdata, act.insn, exp.pc_rdata, exp.insn);
        end
    endtask

    task automatic check_model();
        rvfi_instr_t er;
        logic [63:0] eo;
        er = '0;
        eo = '0;
        if (mq.size() != 0) begin
            er = mq[0].rec;
            eo = mq[0].ord;
        end
        chk("valid", 64'(trace_if.valid_o), 64'(mq.size() != 0));
        chk_rec("rvfi", trace_if.rvfi_o, er);
        chk("order", trace_if.order_o, eo);
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    endtask

    // Reference: pop the head if the consumer took it, then append candidates oldest port first while room remains.
    task automatic model_step();
        if (rst) begin
            mq.delete();
            m_order = '0;
            m_drop  = '0;
            m_ovf   = 1'b0;
        end else begin
            if (mq.size() != 0 && trace_if.ready_i) void'(mq.pop_front());
            for (int k = 0; k < NR; k++) begin
                if (rvfi_i[k].valid | rvfi_i[k].trap) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back('{rec: rvfi_i[k], ord: m_order});
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
                    end
                    m_order = m_order + 64'd1;
                end
            end
        end
    endtask

    task automatic cycle();
        check_model();
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic rdy, input logic v0, input logic t0, input logic [63:0] pc0,
                         input logic v1, input logic t1, input logic [63:0] pc1);
        trace_if.ready_i = rdy;
        rvfi_i[0]        = mk(v0, t0, pc0);
        rvfi_i[1]        = mk(v1, t1, pc1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int thr;
        int sel;

        //            rdy   v0   t0   pc0            v1   t1   pc1         vld  pc             ord     cnt   ovf   drop
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h8000_0000, 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,         64'd0, 4'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h0,    1'b1, 64'h8000_0000, 64'd0, 4'd1, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 64'h100,       1'b1, 1'b0, 64'h104,  1'b0, 64'h0,         64'd0, 4'd0, 1'b0, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 1'b1, 64'h200,  1'b1, 64'h100,       64'd1, 4'd2, 1'b0, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h0,    1'b1, 64'h104,       64'd2, 4'd2, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h0,    1'b1, 64'h200,       64'd3, 4'd1, 1'b0, 32'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h0,    1'b1, 64'h200,       64'd3, 4'd1, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h1000,      1'b1, 1'b0, 64'h1004, 1'b0, 64'h0,         64'd0, 4'd0, 1'b0, 32'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h1008,      1'b1, 1'b0, 64'h100c, 1'b1, 64'h1000,      64'd4, 4'd2, 1'b0, 32'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h1010,      1'b1, 1'b0, 64'h1014, 1'b1, 64'h1000,      64'd4, 4'd4, 1'b0, 32'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h1018,      1'b1, 1'b0, 64'h101c, 1'b1, 64'h1000,      64'd4, 4'd6, 1'b0, 32'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 64'h1020,      1'b1, 1'b0, 64'h1024, 1'b1, 64'h1000,      64'd4, 4'd8, 1'b0, 32'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 64'h1030,      1'b0, 1'b0, 64'h0,    1'b1, 64'h1000,      64'd4, 4'd8, 1'b1, 32'd2};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h0,    1'b1, 64'h1004,      64'd5, 4'd8, 1'b1, 32'd2};
        drain1 = '{64'd6, 64'd7, 64'd8, 64'd9, 64'd10, 64'd11, 64'd14};
        drain2 = '{64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd9, 64'd11};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        model_step();
        chk("rst_valid", 64'(trace_if.valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_order", trace_if.order_o, 64'd0);
        chk("rst_rvfi_pc", trace_if.rvfi_o.pc_rdata, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rdy, vecs[i].v0, vecs[i].t0, vecs[i].pc0, vecs[i].v1, vecs[i].t1, vecs[i].pc1);
            chk($sformatf("tbl%0d_valid", i), 64'(trace_if.valid_o), 64'(vecs[i].e_vld));
            chk($sformatf("tbl%0d_pc", i), trace_if.rvfi_o.pc_rdata, vecs[i].e_pc);
            chk($sformatf("tbl%0d_order", i), trace_if.order_o, vecs[i].e_ord);
            chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(vecs[i].e_cnt));
            chk($sformatf("tbl%0d_overflow", i), 64'(overflow_o), 64'(vecs[i].e_ovf));
            chk($sformatf("tbl%0d_drop", i), 64'(drop_cnt_o), 64'(vecs[i].e_drop));
            cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("drain1_order%0d", i), trace_if.order_o, drain1[i]);
            cycle();
        end
        chk("drain1_empty", 64'(count_o), 64'd0);

        // Fill, pop-while-full, then a partial accept that splits a dual commit.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 64'h2000 + 64'(16 * i), 1'b1, 1'b0, 64'h2008 + 64'(16 * i));
            cycle();
        end
        chk("fill_count", 64'(count_o), 64'd8);
        chk("fill_overflow", 64'(overflow_o), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'h3000, 1'b0, 1'b0, 64'h0);
        cycle();
        chk("fullpop_count", 64'(count_o), 64'd8);
        chk("fullpop_overflow", 64'(overflow_o), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cycle();
        chk("seven_count", 64'(count_o), 64'd7);
        drive(1'b0, 1'b1, 1'b0, 64'h3100, 1'b1, 1'b0, 64'h3104);
        cycle();
        chk("partial_drop", 64'(drop_cnt_o), 64'd1);
        chk("partial_overflow", 64'(overflow_o), 64'd1);
        chk("partial_count", 64'(count_o), 64'd8);
        drive(1'b1, 1'b1, 1'b0, 64'h3200, 1'b0, 1'b0, 64'h0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain2_order%0d", i), trace_if.order_o, drain2[i]);
            cycle();
        end

        // Reset while occupied and while a commit is presented.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 64'h4000, 1'b1, 1'b0, 64'h4004);
        cycle();
        cycle();
        drive(1'b0, 1'b0, 1'b1, 64'h4100, 1'b0, 1'b0, 64'h0);
        cycle();
        chk("pre_rst_count", 64'(count_o), 64'd5);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'h4200, 1'b1, 1'b0, 64'h4204);
        cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        chk("midrst_valid", 64'(trace_if.valid_o), 64'd0);
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_drop", 64'(drop_cnt_o), 64'd0);
        chk("midrst_overflow", 64'(overflow_o), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'h5000, 1'b0, 1'b0, 64'h0);
        cycle();
        chk("postrst_valid", 64'(trace_if.valid_o), 64'd1);
        chk("postrst_order", trace_if.order_o, 64'd0);
        chk("postrst_pc", trace_if.rvfi_o.pc_rdata, 64'h5000);

        thr = 50;
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) thr = int'($urandom_range(10, 95));
            rst = ($urandom_range(0, 199) == 0);
            trace_if.ready_i = (int'($urandom_range(0, 99)) < thr);
            for (int k = 0; k < NR; k++) begin
                sel = int'($urandom_range(0, 5));
                rvfi_i[k] = mk((sel >= 1 && sel <= 3), (sel == 3 || sel == 4), {$urandom, $urandom});
            end
            cycle();
        end
        rst = 1'b0;
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
